// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/done handshake and operand/result bus for serial_adder
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;

    modport master (
        output start, a_in, b_in,
        input  busy, done, sum_out, carry_out
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, sum_out, carry_out
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder built on two half adders per bit slot
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_acc;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    logic             w_p;
    logic             w_g1;
    logic             w_s;
    logic             w_g2;
    logic             w_co;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;

    // Full-adder bit cell: operand bits first, then fold in the held carry.
    half_adder u_ha0 (
        .i_a (r_sa[0]),
        .i_b (r_sb[0]),
        .o_s (w_p),
        .o_c (w_g1)
    );

    half_adder u_ha1 (
        .i_a (w_p),
        .i_b (r_c),
        .o_s (w_s),
        .o_c (w_g2)
    );

    assign w_co   = w_g1 | w_g2;
    assign w_last = (r_cnt == LAST_BIT);

    // A one-bit accumulator has no older bits to shift down.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign w_acc_next = w_s;
        end else begin : g_acc_wn
            assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: accept start only in IDLE, return after the last bit slot.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_SHIFT;
            S_SHIFT: if (w_last)    w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: operand capture, per-bit shifting, and result publication on the last bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_acc   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sa   <= bus.a_in;
                        r_sb   <= bus.b_in;
                        r_acc  <= '0;
                        r_c    <= 1'b0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_acc <= w_acc_next;
                    r_c   <= w_co;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum   <= w_acc_next;
                        r_carry <= w_co;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.sum_out   = r_sum;
    assign bus.carry_out = r_carry;
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that consumes the half-adder primitive. It adds two WIDTH-bit operands LSB-first, one bit per clock, and presents a registered sum and carry-out with a start/done handshake. The bit cell is a full adder built from two `half_adder` instances plus an OR gate. The carry is held in a flip-flop between bit slots. The block sits directly downstream of `half_adder` and is the first sequential arithmetic stage built on it.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range WIDTH >= 1.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: request an addition; sampled only in IDLE.
- `a_in` input WIDTH: operand A; captured on the edge that accepts `start`.
- `b_in` input WIDTH: operand B; captured on the edge that accepts `start`.
- `busy` output 1: high while an addition is in progress.
- `done` output 1: single-cycle pulse; `sum_out` and `carry_out` are valid from this cycle onward.
- `sum_out` output WIDTH: registered sum of the last completed addition, modulo 2^WIDTH.
- `carry_out` output 1: registered carry out of bit WIDTH-1 for the last completed addition.

## Operation
- **States.** Two states, IDLE and SHIFT. Reset forces IDLE.
- **Internal registers.**
  - `sa`, `sb`: WIDTH-bit shift registers for the operands.
  - `acc`: WIDTH-bit shift register for the result.
  - `c`: carry flip-flop.
  - `cnt`: bit counter, $clog2(WIDTH+1) bits wide.
- **Bit cell (combinational).** The first half_adder computes (`sa[0]`, `sb[0]`) -> (p, g1). The second half_adder computes (p, `c`) -> (s, g2). The cell carry is co = g1 | g2.
- **IDLE, start = 1.**
  - `sa` <= `a_in`, `sb` <= `b_in`, `c` <= 0, `cnt` <= 0, `acc` <= 0.
  - `busy` <= 1; state goes to SHIFT.
- **IDLE, start = 0.** All registers hold; `busy` = 0.
- **SHIFT, every edge.**
  - `sa` and `sb` shift right, filling with 0.
  - `acc` <= {s, `acc`[WIDTH-1:1]}.
  - `c` <= co; `cnt` <= `cnt` + 1.
- **SHIFT, edge where `cnt` == WIDTH-1 (last bit).**
  - `sum_out` <= {s, `acc`[WIDTH-1:1]}; `carry_out` <= co.
  - `done` <= 1, `busy` <= 0; state goes to IDLE.
- **`done` pulse.** `done` is cleared on every edge where it is not set, so it is exactly one cycle wide.
- **Busy period.** `start` is ignored while in SHIFT; `a_in` and `b_in` may change freely without effect.
- **Result hold.** `sum_out` and `carry_out` hold their value until the next completion. They are never disturbed mid-operation.
- **Arithmetic.** {`carry_out`, `sum_out`} equals `a_in` + `b_in` exactly, a (WIDTH+1)-bit result with no truncation of the carry.

## Timing
- **Reset values.** `busy` = 0, `done` = 0, `sum_out` = 0, `carry_out` = 0; state IDLE; internal registers 0.
- **Reset mid-operation.** A rising edge with `rst` = 1 aborts the addition and returns all outputs to their reset values. No `done` is produced. `rst` has priority over `start`.
- **Latency.** Call the edge that accepts `start` E0.
  - Bits are processed on edges E1..EWIDTH.
  - `busy` is high from after E0 until EWIDTH.
  - `done` = 1 and the results are valid in the cycle after EWIDTH.
  - Total latency is WIDTH cycles from acceptance to `done`.
- **Throughput.** `start` asserted in the same cycle as `done` (state is already IDLE) is accepted. Back-to-back additions therefore run every WIDTH+1 edges with no bubble beyond the IDLE acceptance edge.
- **WIDTH = 1.** SHIFT lasts one edge (E1); `done` follows E1.

## Test plan
- **Reset.** Hold `rst` for 2 cycles, then release -> `busy` = 0, `done` = 0, `sum_out` = 0x00, `carry_out` = 0 before any start.
- **Max carry ripple, WIDTH = 8.** `a_in` = 0xFF, `b_in` = 0x01, pulse `start` -> `done` exactly 8 cycles after the accept edge, `sum_out` = 0x00, `carry_out` = 1, `done` high for one cycle only.
- **No carry, WIDTH = 8.** 0xA5 + 0x5A -> `sum_out` = 0xFF, `carry_out` = 0. Then, in the `done` cycle, start 0x80 + 0x80 -> a second `done` 8 cycles later with `sum_out` = 0x00, `carry_out` = 1.
- **Start ignored while busy.** Start 0x0F + 0x01; at cycle 3 assert `start` with `a_in` = 0xFF, `b_in` = 0xFF -> result `sum_out` = 0x10, `carry_out` = 0; only one `done`.
- **Reset mid-operation.** Start 0x7F + 0x7F, assert `rst` at cycle 4 -> `busy` = 0, `sum_out` = 0x00, no `done` pulse. A fresh start of 0x7F + 0x7F then gives `sum_out` = 0xFE, `carry_out` = 0.
- **WIDTH = 1, all four input pairs.** (0,0)/(0,1)/(1,0)/(1,1) -> {`carry_out`, `sum_out`} = 00/01/01/10, `done` one cycle after each accept, matching the half_adder truth table.
